decimal_to_other_system: RTL and testbench

DECIMAL_TO_OTHER_SYSTEM -- requirements
Module: decimal_to_other_system

---
 rtl/decimal_to_other_system.sv | 116 +++++++++++
 tb/tb_decimal_to_other_system.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decimal_to_other_system.sv
// decimal_to_other_system
//   Converts a 32-bit unsigned value into an ASCII string in radix 2..16,
//   producing one digit per clock, least-significant digit first.
//   The result is 16 characters, right-justified and padded with spaces.
//
// Ports
//   clk       in   1    clock, rising edge
//   rst       in   1    asynchronous active-high reset
//   start     in   1    conversion request, accepted when busy=0
//   decimal   in   32   value to convert
//   base      in   4    radix: 2..15 literal, 0 means 16, 1 is invalid
//   result    out  128  16 ASCII chars, char 15 in [127:120]
//   busy      out  1    conversion in progress
//   done      out  1    one-cycle pulse when result is final
//   error     out  1    last accepted request had base=1
//   overflow  out  1    last result needed more than 16 digits
//
// Configuration
//   LOWERCASE_HEX_EN  defined: digits 10-15 are 'a'-'f'; undefined: 'A'-'F'.

module decimal_to_other_system (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  decimal,
    input  logic [3:0]   base,
    output logic [127:0] result,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         overflow
);

`ifdef LOWERCASE_HEX_EN
    localparam logic [7:0] LetterBase = 8'h61;
`else
    localparam logic [7:0] LetterBase = 8'h41;
`endif

    localparam logic [127:0] Blank    = {16{8'h20}};
    localparam logic [127:0] ErrorStr = {{11{8'h20}}, 8'h45, 8'h52, 8'h52, 8'h4F, 8'h52};

    logic [127:0] r_result;
    logic         r_busy;
    logic         r_done;
    logic         r_error;
    logic         r_overflow;
    logic [31:0]  r_value;
    logic [4:0]   r_radix;
    logic [5:0]   r_count;

    logic [31:0]  w_divisor;
    logic [31:0]  w_quot;
    logic [4:0]   w_rem;
    logic [7:0]   w_char;

    // Radix 0/1 never reaches the digit path; substitute 2 so the divider
    // never sees a zero divisor.
    assign w_divisor = (r_radix < 5'd2) ? 32'd2 : {27'd0, r_radix};
    assign w_quot    = r_value / w_divisor;
    assign w_rem     = 5'(r_value % w_divisor);
    assign w_char    = (w_rem < 5'd10) ? (8'h30 + {3'd0, w_rem})
                                       : (LetterBase + {3'd0, w_rem} - 8'd10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= Blank;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
            r_value    <= 32'd0;
            r_radix    <= 5'd0;
            r_count    <= 6'd0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_result   <= Blank;
                r_busy     <= 1'b1;
                r_error    <= 1'b0;
                r_overflow <= 1'b0;
                r_value    <= decimal;
                r_radix    <= (base == 4'd0) ? 5'd16 : {1'b0, base};
                r_count    <= 6'd0;
            end else if (r_busy) begin
                if (r_radix == 5'd1) begin
                    r_result <= ErrorStr;
                    r_error  <= 1'b1;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end else begin
                    // Only the 16 least-significant digits fit; later ones
                    // only flag overflow.
                    if (r_count < 6'd16) begin
                        r_result[{r_count[3:0], 3'b000} +: 8] <= w_char;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                    r_count <= r_count + 6'd1;
                    r_value <= w_quot;
                    if (w_quot == 32'd0) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
            end
        end
    end

    assign result   = r_result;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_decimal_to_other_system.sv
module tb_decimal_to_other_system;

    logic         clk;
    logic         rst;
    logic         start;
    logic [31:0]  decimal;
    logic [3:0]   base;
    logic [127:0] result;
    logic         busy;
    logic         done;
    logic         error;
    logic         overflow;

    decimal_to_other_system dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .decimal  (decimal),
        .base     (base),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] res;
        logic         err;
        logic         ovf;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: build the digit string by repeated division, then keep the
    // rightmost 16 characters and left-pad with spaces.
    function automatic void model(input logic [31:0] d, input logic [3:0] bs,
                                  output logic [127:0] res, output logic err,
                                  output logic ovf, output int n);
        int unsigned b;
        longint unsigned v;
        string s;
        string e;
        int len;
        int first;
        b   = (bs == 4'd0) ? 16 : int'(bs);
        res = {16{8'h20}};
        if (b == 1) begin
            e = "ERROR";
            for (int i = 0; i < 5; i++) res[8*(4-i) +: 8] = e[i];
            err = 1'b1;
            ovf = 1'b0;
            n   = 1;
            return;
        end
        s = "";
        v = longint'(d);
        do begin
            int unsigned dig;
            byte ch;
            dig = int'(v % b);
`ifdef LOWERCASE_HEX_EN
            ch = (dig < 10) ? byte'(48 + dig) : byte'(97 + dig - 10);
`else
            ch = (dig < 10) ? byte'(48 + dig) : byte'(65 + dig - 10);
`endif
            s = $sformatf("%c%s", ch, s);
            v = v / b;
        end while (v != 0);
        len   = s.len();
        n     = len;
        ovf   = (len > 16);
        err   = 1'b0;
        first = (len > 16) ? len - 16 : 0;
        for (int i = first; i < len; i++) res[8*(len-1-i) +: 8] = s[i];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1 required no done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("error", 128'(error), 128'(e.err));
                check("overflow", 128'(overflow), 128'(e.ovf));
                check("busy_at_done", 128'(busy), 128'd0);
                check("latency", 128'(cyc - e.acc_cyc), 128'(e.lat));
            end
        end
    end

    // Issue one request; then keep start high with junk for every edge the
    // conversion is still busy, all of which must be ignored.
    task automatic conv(input logic [31:0] d, input logic [3:0] bs, input bit noise);
        exp_t e;
        int n;
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: got busy=1 required busy=0");
        end
        start   = 1'b1;
        decimal = d;
        base    = bs;
        model(d, bs, e.res, e.err, e.ovf, n);
        e.lat = n;
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start   = noise;
            decimal = $urandom;
            base    = 4'($urandom_range(0, 15));
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int guard;
        rst     = 1'b1;
        start   = 1'b0;
        decimal = 32'd0;
        base    = 4'd0;
        #1;
        check("rst_result", result, {16{8'h20}});
        check("rst_flags", {124'd0, busy, done, error, overflow}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        conv(32'd10, 4'd2, 1'b0);
        conv(32'd255, 4'd0, 1'b1);
        conv(32'd100, 4'd8, 1'b0);
        conv(32'd500, 4'd10, 1'b1);
        conv(32'd50, 4'd1, 1'b1);
        conv(32'd0, 4'd2, 1'b0);
        conv(32'hFFFF_FFFF, 4'd2, 1'b1);
        conv(32'hFFFF_FFFF, 4'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            conv(d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Drain before the abort test so no expectation is outstanding.
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end

        // Abort a long conversion with reset; no done may follow.
        start   = 1'b1;
        decimal = 32'hFFFF_FFFF;
        base    = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_result", result, {16{8'h20}});
        check("abort_flags", {124'd0, busy, done, error, overflow}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // First start after reset must be accepted.
        conv(32'd35, 4'd6, 1'b0);
        conv(32'd1234567, 4'd13, 1'b1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
